// File: rtl/ddfs_phase_ctrl.sv
// Phase accumulator and LUT addressing for a DDFS, with tuning-word updates
// deferred to the next sample boundary so the output phase never glitches.
//
// state | meaning
// IDLE  | accumulator held at 0, lut_addr shows the phase offset, config applies at once
// RUN   | accumulating on sample_tick, config accepted into pending registers
// PEND  | new config waiting; the next sample_tick makes it active, cfg_ready low
module ddfs_phase_ctrl #(
  parameter int PHASE_BITS  = 32,
  parameter int LUT_DEPTH   = 10,
  parameter int LUT_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  sample_tick,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [PHASE_BITS-1:0] cfg_ftw,
  input  logic [LUT_DEPTH-1:0]  cfg_phase,
  output logic [LUT_DEPTH-1:0]  lut_addr,
  output logic                  ref_valid,
  output logic                  period_start,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

  state_t                  state_q, state_d;
  logic [PHASE_BITS-1:0]   acc_q, acc_d;
  logic [PHASE_BITS-1:0]   ftw_q, ftw_d;
  logic [LUT_DEPTH-1:0]    phase_q, phase_d;
  logic [PHASE_BITS-1:0]   pend_ftw_q, pend_ftw_d;
  logic [LUT_DEPTH-1:0]    pend_phase_q, pend_phase_d;
  logic [LUT_DEPTH-1:0]    addr_q, addr_d;
  logic                    upd_q, upd_d;
  logic                    wrap_q, wrap_d;
  logic [LUT_LATENCY-1:0]  vld_q;
  logic [LUT_LATENCY-1:0]  per_q;

  logic                    cfg_hs;
  logic [PHASE_BITS-1:0]   step_ftw;
  logic [LUT_DEPTH-1:0]    step_phase;
  logic [PHASE_BITS:0]     sum;

  assign cfg_ready    = rst_n && (state_q != S_PEND);
  assign cfg_hs       = cfg_valid && cfg_ready;
  assign busy         = (state_q != S_IDLE);
  assign lut_addr     = addr_q;
  assign ref_valid    = vld_q[LUT_LATENCY-1];
  assign period_start = per_q[LUT_LATENCY-1] & vld_q[LUT_LATENCY-1];

  // In PEND the tick advances with the pending values, which become active in the same edge.
  assign step_ftw   = (state_q == S_PEND) ? pend_ftw_q : ftw_q;
  assign step_phase = (state_q == S_PEND) ? pend_phase_q : phase_q;
  assign sum        = {1'b0, acc_q} + {1'b0, step_ftw};

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ftw_d        = ftw_q;
    phase_d      = phase_q;
    pend_ftw_d   = pend_ftw_q;
    pend_phase_d = pend_phase_q;
    addr_d       = addr_q;
    upd_d        = 1'b0;
    wrap_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        acc_d  = '0;
        addr_d = phase_q;
        if (cfg_hs) begin
          ftw_d   = cfg_ftw;
          phase_d = cfg_phase;
          addr_d  = cfg_phase;
        end
        if (start && !stop) state_d = S_RUN;
      end
      S_RUN, S_PEND: begin
        if (stop) begin
          state_d      = S_IDLE;
          acc_d        = '0;
          pend_ftw_d   = '0;
          pend_phase_d = '0;
          addr_d       = phase_q;
        end else begin
          if (sample_tick) begin
            acc_d  = sum[PHASE_BITS-1:0];
            addr_d = sum[PHASE_BITS-1 -: LUT_DEPTH] + step_phase;
            upd_d  = 1'b1;
            wrap_d = sum[PHASE_BITS];
            if (state_q == S_PEND) begin
              ftw_d   = pend_ftw_q;
              phase_d = pend_phase_q;
              state_d = S_RUN;
            end
          end
          if (state_q == S_RUN && cfg_hs) begin
            pend_ftw_d   = cfg_ftw;
            pend_phase_d = cfg_phase;
            state_d      = S_PEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      ftw_q        <= '0;
      phase_q      <= '0;
      pend_ftw_q   <= '0;
      pend_phase_q <= '0;
      addr_q       <= '0;
      upd_q        <= 1'b0;
      wrap_q       <= 1'b0;
      vld_q        <= '0;
      per_q        <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ftw_q        <= ftw_d;
      phase_q      <= phase_d;
      pend_ftw_q   <= pend_ftw_d;
      pend_phase_q <= pend_phase_d;
      addr_q       <= addr_d;
      upd_q        <= upd_d;
      wrap_q       <= wrap_d;
      // Pipeline is not cleared by stop so in-flight samples still come out.
      vld_q[0]     <= upd_q;
      per_q[0]     <= wrap_q;
      for (int i = 1; i < LUT_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        per_q[i] <= per_q[i-1];
      end
    end
  end

endmodule
